router_pkt_tx: RTL and testbench
================================

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 SHALL have parameter TIMEOUT, default 32: consecutive busy cycles before abort (used only with ROUTER_TX_TIMEOUT_EN).
REQ-002 SHALL have ports, one clock, async active-high reset:
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  request to send one packet; sampled in IDLE only
- dest_addr  in  2  destination port 0..2; 3 invalid
- payload_len  in  6  payload byte count 1..63; 0 invalid
- src_data  in  8  payload byte from upstream
- src_valid  in  1  src_data valid
- src_ready  out  1  byte accepted on edge where src_valid & src_ready
- busy  in  1  router stall; byte on data_out not consumed while high
- pkt_valid  out  1  high during header and payload bytes
- data_out  out  8  packet byte to router
- tx_done  out  1  one-cycle pulse after parity byte consumed
- start_err  out  1  one-cycle pulse on rejected start
- tx_abort  out  1  one-cycle pulse on timeout abort (0 when feature absent)

Function
REQ-003 SHALL implement FSM states IDLE, LOAD, HEADER, PAYLOAD, PARITY.
REQ-004 IDLE: start=1 with dest_addr!=3 and payload_len!=0 SHALL latch header={payload_len,dest_addr}, clear parity and index, enter LOAD next cycle.
REQ-005 IDLE: start=1 with dest_addr=3 or payload_len=0 SHALL pulse start_err next cycle and remain IDLE.
REQ-006 start outside IDLE SHALL be ignored without error.
REQ-007 LOAD: src_ready=1; each accepted byte SHALL be written to a 64x8 internal buffer at index, index incremented, parity^=byte.
REQ-008 Acceptance of byte payload_len-1 SHALL move to HEADER on the same edge; src_ready SHALL be 0 in all other states.
REQ-009 HEADER: pkt_valid=1, data_out=header; on edge with busy=0, parity^=header, index cleared, enter PAYLOAD.
REQ-010 PAYLOAD: pkt_valid=1, data_out=buffer[index]; on edge with busy=0 index increments; after byte payload_len-1 consumed, enter PARITY.
REQ-011 PARITY: pkt_valid=0, data_out=parity (XOR of header and all payload bytes); on edge with busy=0 enter IDLE and pulse tx_done next cycle.
REQ-012 busy=1 SHALL hold state, index, data_out and pkt_valid unchanged.
REQ-013 IDLE/LOAD: pkt_valid=0, data_out=0.
REQ-014 pkt_valid and data_out SHALL be decoded only from registered state; no combinational path from busy or src_* to them.
REQ-015 Zero-bubble: with busy=0, header through parity occupy payload_len+2 consecutive cycles; header appears cycle after last payload byte accepted.
REQ-016 Back-to-back: start may be accepted in the first IDLE cycle after PARITY.

Reset
REQ-017 reset=1 SHALL asynchronously force IDLE, pkt_valid=0, data_out=0, src_ready=0, tx_done=0, start_err=0, tx_abort=0, index/parity/header/busy counter=0; buffer contents not reset.
REQ-018 reset mid-packet SHALL drop pkt_valid immediately; no parity byte is sent after release.

Configuration
REQ-019 Macro ROUTER_TX_TIMEOUT_EN defined: counter increments each cycle busy=1 in HEADER/PAYLOAD/PARITY, clears on busy=0 or state change; reaching TIMEOUT SHALL enter IDLE and pulse tx_abort next cycle, no tx_done.
REQ-020 Macro undefined: no counter; transmitter waits on busy indefinitely; tx_abort tied 0.

Verification
REQ-021 start, addr=1, len=3, bytes A1,B2,C3, busy=0 -> data_out 0D,A1,B2,C3 with pkt_valid=1, then 0D^A1^B2^C3=DD with pkt_valid=0, tx_done pulse.
REQ-022 start with addr=3 len=5, then addr=0 len=0 -> start_err pulse each, src_ready stays 0, state IDLE.
REQ-023 len=2, busy high 4 cycles during second payload byte -> byte and pkt_valid held 4 cycles, sequence intact, correct parity.
REQ-024 src_valid gaps during LOAD -> no output activity until all len bytes accepted; header the following cycle.
REQ-025 reset asserted during PAYLOAD -> pkt_valid=0 same cycle; new packet after release transmits correctly.
REQ-026 With ROUTER_TX_TIMEOUT_EN, TIMEOUT=32, busy held 32 cycles in HEADER -> tx_abort pulse, IDLE, no tx_done; without macro, busy 100 cycles then released -> packet completes.

Source files
------------

// File: rtl/router_pkt_tx.sv
// rtl/router_pkt_tx.sv - router packet transmitter: buffers a payload, then sends header, payload and parity
//
// Loads payload_len bytes from an upstream stream into an internal 64x8 buffer,
// then emits {payload_len, dest_addr}, the buffered bytes and an XOR parity byte
// to the router, honouring the router's busy stall.
//
// Ports:
//   clock        sole clock, rising edge
//   reset        asynchronous, active-high
//   start        request to send one packet (sampled in IDLE only)
//   dest_addr    destination port 0..2 (3 is invalid)
//   payload_len  payload byte count 1..63 (0 is invalid)
//   src_data     payload byte from upstream
//   src_valid    src_data valid
//   src_ready    byte accepted on an edge where src_valid & src_ready
//   busy         router stall; the byte on data_out is not consumed while high
//   pkt_valid    high during header and payload bytes
//   data_out     packet byte to the router
//   tx_done      one-cycle pulse after the parity byte is consumed
//   start_err    one-cycle pulse on a rejected start
//   tx_abort     one-cycle pulse on a busy timeout abort
//
// Build option: define ROUTER_TX_TIMEOUT_EN to abort a packet after TIMEOUT
// consecutive busy cycles; otherwise the transmitter waits on busy forever and
// tx_abort is tied low.

module router_pkt_tx #(
    parameter int TIMEOUT = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] dest_addr,
    input  logic [5:0] payload_len,
    input  logic [7:0] src_data,
    input  logic       src_valid,
    output logic       src_ready,
    input  logic       busy,
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       tx_done,
    output logic       start_err,
    output logic       tx_abort
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY
    } state_t;

    state_t     state_q,     state_d;
    logic [7:0] header_q,    header_d;
    logic [5:0] index_q,     index_d;
    logic [7:0] parity_q,    parity_d;
    logic       tx_done_q,   tx_done_d;
    logic       start_err_q, start_err_d;
    logic       tx_abort_q,  tx_abort_d;

    logic [7:0] buf_mem [0:63];
    logic       buf_we;
    logic [5:0] last_index;

    // Non-positive TIMEOUT values are not supported.
    if (TIMEOUT < 1) begin : g_timeout_range
    end

`ifdef ROUTER_TX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
`endif

    // Length is held in the header's upper six bits, so no separate length register.
    assign last_index = header_q[7:2] - 6'd1;

    // Registered-state decode only: nothing from busy or src_* reaches these.
    assign src_ready = (state_q == S_LOAD);
    assign pkt_valid = (state_q == S_HEADER) || (state_q == S_PAYLOAD);
    assign tx_done   = tx_done_q;
    assign start_err = start_err_q;
    assign tx_abort  = tx_abort_q;

    always_comb begin
        data_out = 8'h00;
        case (state_q)
            S_HEADER:  data_out = header_q;
            S_PAYLOAD: data_out = buf_mem[index_q];
            S_PARITY:  data_out = parity_q;
            default:   data_out = 8'h00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        header_d    = header_q;
        index_d     = index_q;
        parity_d    = parity_q;
        tx_done_d   = 1'b0;
        start_err_d = 1'b0;
        tx_abort_d  = 1'b0;
        buf_we      = 1'b0;
`ifdef ROUTER_TX_TIMEOUT_EN
        busy_cnt_d  = '0;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (dest_addr == 2'd3 || payload_len == 6'd0) begin
                        start_err_d = 1'b1;
                    end else begin
                        header_d = {payload_len, dest_addr};
                        index_d  = 6'd0;
                        parity_d = 8'h00;
                        state_d  = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (src_valid) begin
                    buf_we   = 1'b1;
                    index_d  = index_q + 6'd1;
                    parity_d = parity_q ^ src_data;
                    if (index_q == last_index) begin
                        state_d = S_HEADER;
                    end
                end
            end
            S_HEADER: begin
                if (!busy) begin
                    parity_d = parity_q ^ header_q;
                    index_d  = 6'd0;
                    state_d  = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (!busy) begin
                    if (index_q == last_index) begin
                        state_d = S_PARITY;
                    end else begin
                        index_d = index_q + 6'd1;
                    end
                end
            end
            S_PARITY: begin
                if (!busy) begin
                    tx_done_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef ROUTER_TX_TIMEOUT_EN
        // Any busy cycle in an output state counts; a non-busy cycle always
        // moves the FSM on, so the default clear covers the state-change case.
        if (busy && (state_q == S_HEADER || state_q == S_PAYLOAD || state_q == S_PARITY)) begin
            if (busy_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                state_d    = S_IDLE;
                tx_abort_d = 1'b1;
            end else begin
                busy_cnt_d = busy_cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            header_q    <= 8'h00;
            index_q     <= 6'd0;
            parity_q    <= 8'h00;
            tx_done_q   <= 1'b0;
            start_err_q <= 1'b0;
            tx_abort_q  <= 1'b0;
`ifdef ROUTER_TX_TIMEOUT_EN
            busy_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            header_q    <= header_d;
            index_q     <= index_d;
            parity_q    <= parity_d;
            tx_done_q   <= tx_done_d;
            start_err_q <= start_err_d;
            tx_abort_q  <= tx_abort_d;
`ifdef ROUTER_TX_TIMEOUT_EN
            busy_cnt_q  <= busy_cnt_d;
`endif
        end
    end

    // Payload storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (buf_we) begin
            buf_mem[index_q] <= src_data;
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb/tb_router_pkt_tx.sv - directed self-checking bench for router_pkt_tx

module tb_router_pkt_tx;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] dest_addr = 2'd0;
    logic [5:0] payload_len = 6'd0;
    logic [7:0] src_data = 8'h00;
    logic       src_valid = 1'b0;
    logic       src_ready;
    logic       busy = 1'b0;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       tx_done;
    logic       start_err;
    logic       tx_abort;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] pay [0:63];

    router_pkt_tx #(.TIMEOUT(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dest_addr   (dest_addr),
        .payload_len (payload_len),
        .src_data    (src_data),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .busy        (busy),
        .pkt_valid   (pkt_valid),
        .data_out    (data_out),
        .tx_done     (tx_done),
        .start_err   (start_err),
        .tx_abort    (tx_abort)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Sends one packet from pay[]. gap>0 inserts gap idle cycles before every
    // odd byte during LOAD (with a stray invalid start driven, which must be ignored).
    // The item at output position stall_at (0 = header) is held with busy for stall_len cycles.
    task automatic run_pkt(input logic [1:0] addr, input logic [5:0] len,
                           input int gap, input int stall_at, input int stall_len);
        logic [7:0] hdr;
        logic [7:0] par;
        logic [7:0] exp;
        hdr = {len, addr};
        par = hdr;
        for (int i = 0; i < len; i++) par = par ^ pay[i];

        start = 1'b1; dest_addr = addr; payload_len = len;
        tick;
        start = 1'b0;
        check("load_ready", src_ready, 1);
        check("load_pv", pkt_valid, 0);
        for (int i = 0; i < len; i++) begin
            if (gap > 0 && (i % 2) == 1) begin
                src_valid = 1'b0;
                start = 1'b1; dest_addr = 2'd3;
                for (int g = 0; g < gap; g++) begin
                    tick;
                    check("gap_pv", pkt_valid, 0);
                    check("gap_dout", data_out, 0);
                    check("gap_serr", start_err, 0);
                end
                start = 1'b0;
            end
            src_valid = 1'b1; src_data = pay[i];
            tick;
        end
        src_valid = 1'b0;
        check("hdr_ready", src_ready, 0);
        for (int k = 0; k <= len; k++) begin
            exp = (k == 0) ? hdr : pay[k-1];
            check("out_pv", pkt_valid, 1);
            check("out_dout", data_out, exp);
            if (k == stall_at) begin
                busy = 1'b1;
                for (int j = 0; j < stall_len; j++) begin
                    tick;
                    check("stall_pv", pkt_valid, 1);
                    check("stall_dout", data_out, exp);
                end
                busy = 1'b0;
            end
            tick;
        end
        check("par_pv", pkt_valid, 0);
        check("par_dout", data_out, par);
        check("par_done", tx_done, 0);
        tick;
        check("done_pulse", tx_done, 1);
        check("done_pv", pkt_valid, 0);
        check("done_abort", tx_abort, 0);
        tick;
        check("done_clear", tx_done, 0);
    endtask

    initial begin
        // Reset state
        tick; tick;
        check("rst_pv", pkt_valid, 0);
        check("rst_dout", data_out, 0);
        check("rst_ready", src_ready, 0);
        check("rst_done", tx_done, 0);
        check("rst_serr", start_err, 0);
        check("rst_abort", tx_abort, 0);
        reset = 1'b0;
        tick;

        // Basic packet: addr 1, len 3, A1 B2 C3 -> 0D A1 B2 C3, parity DD
        pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
        start = 1'b1; dest_addr = 2'd1; payload_len = 6'd3;
        tick;
        start = 1'b0;
        src_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin src_data = pay[i]; tick; end
        src_valid = 1'b0;
        check("ex_hdr", data_out, 8'h0D);
        check("ex_hdr_pv", pkt_valid, 1);
        tick; check("ex_b0", data_out, 8'hA1);
        tick; check("ex_b1", data_out, 8'hB2);
        tick; check("ex_b2", data_out, 8'hC3);
        check("ex_b2_pv", pkt_valid, 1);
        tick; check("ex_par", data_out, 8'hDD);
        check("ex_par_pv", pkt_valid, 0);
        tick; check("ex_done", tx_done, 1);
        // Back-to-back: start in first IDLE cycle after parity, same packet via model
        run_pkt(2'd1, 6'd3, 0, -1, 0);

        // Rejected starts
        start = 1'b1; dest_addr = 2'd3; payload_len = 6'd5;
        tick;
        start = 1'b0;
        check("err_a3_pulse", start_err, 1);
        check("err_a3_ready", src_ready, 0);
        tick;
        check("err_a3_clear", start_err, 0);
        check("err_a3_idle", src_ready, 0);
        start = 1'b1; dest_addr = 2'd0; payload_len = 6'd0;
        tick;
        start = 1'b0;
        check("err_l0_pulse", start_err, 1);
        check("err_l0_ready", src_ready, 0);
        tick;
        check("err_l0_clear", start_err, 0);
        check("err_l0_pv", pkt_valid, 0);

        // len 2, busy 4 cycles on the second payload byte
        pay[0] = 8'h5A; pay[1] = 8'h3C;
        run_pkt(2'd2, 6'd2, 0, 2, 4);

        // src_valid gaps during LOAD with stray starts
        for (int i = 0; i < 5; i++) pay[i] = 8'h11 * (i + 1);
        run_pkt(2'd0, 6'd5, 2, -1, 0);

        // Single-byte and maximum-length packets
        pay[0] = 8'hFF;
        run_pkt(2'd2, 6'd1, 0, 1, 1);
        for (int i = 0; i < 63; i++) pay[i] = 8'(i * 7 + 3);
        run_pkt(2'd1, 6'd63, 0, 63, 2);

        // Reset mid-payload
        for (int i = 0; i < 4; i++) pay[i] = 8'hC0 + 8'(i);
        start = 1'b1; dest_addr = 2'd2; payload_len = 6'd4;
        tick;
        start = 1'b0;
        src_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin src_data = pay[i]; tick; end
        src_valid = 1'b0;
        tick; tick;
        check("mid_pv", pkt_valid, 1);
        check("mid_dout", data_out, 8'hC1);
        reset = 1'b1;
        #1;
        check("arst_pv", pkt_valid, 0);
        check("arst_dout", data_out, 0);
        tick;
        reset = 1'b0;
        tick;
        check("post_rst_pv", pkt_valid, 0);
        check("post_rst_dout", data_out, 0);
        check("post_rst_done", tx_done, 0);
        tick;
        check("post_rst_dout2", data_out, 0);
        run_pkt(2'd0, 6'd4, 0, -1, 0);

`ifdef ROUTER_TX_TIMEOUT_EN
        // Busy held 32 cycles in HEADER -> abort
        pay[0] = 8'h77;
        start = 1'b1; dest_addr = 2'd1; payload_len = 6'd1;
        tick;
        start = 1'b0;
        src_valid = 1'b1; src_data = 8'h77;
        tick;
        src_valid = 1'b0;
        busy = 1'b1;
        for (int j = 0; j < 31; j++) tick;
        check("to_hold_pv", pkt_valid, 1);
        check("to_hold_abort", tx_abort, 0);
        tick;
        busy = 1'b0;
        check("to_abort", tx_abort, 1);
        check("to_pv", pkt_valid, 0);
        check("to_done", tx_done, 0);
        tick;
        check("to_abort_clear", tx_abort, 0);
        check("to_done2", tx_done, 0);
        check("to_idle_ready", src_ready, 0);
        run_pkt(2'd1, 6'd1, 0, -1, 0);
`else
        // Busy 100 cycles on the header, then released: packet completes
        pay[0] = 8'h12; pay[1] = 8'h34;
        run_pkt(2'd1, 6'd2, 0, 0, 100);
        check("no_to_abort", tx_abort, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
